// File: rtl/frame_deframer.sv
// -----------------------------------------------------------------------------
// frame_deframer
//   Receive side of a length-prefixed byte framing. The first byte of each frame
//   is the payload length L, followed by L payload bytes. The length is offered
//   on a single-entry slot (len_*), the payload bytes through a circular FIFO
//   (dout_*). A small 32-bit register port (cfg_*) exposes enable, frame and
//   byte counters and status.
//
//   Optional feature (macro FRAME_DEFRAMER_CHECKSUM_EN): every frame carries one
//   trailing XOR checksum byte, checked in a CHK state; mismatches increment an
//   ERRORS counter and set a sticky STATUS bit. Without the macro there is no
//   trailer, ERRORS and STATUS bit 16 read 0.
//
// Ports
//   CLK, RST_N              clock (rising edge), async active-low reset
//   din_value/en/rdy        incoming stream byte (header, payload, trailer)
//   dout_value/en/rdy       head of the payload FIFO, popped by dout_en
//   len_value/en/rdy        length of the oldest announced frame
//   cfg_address/data_in/op/en, cfg_data_out, cfg_rdy
//                           register port: 0x00 CTRL, 0x01 FRAMES, 0x02 BYTES,
//                           0x03 STATUS, 0x04 ERRORS
// -----------------------------------------------------------------------------
module frame_deframer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  din_value,
    input  logic        din_en,
    output logic        din_rdy,
    input  logic        dout_en,
    output logic [7:0]  dout_value,
    output logic        dout_rdy,
    input  logic        len_en,
    output logic [7:0]  len_value,
    output logic        len_rdy,
    input  logic [7:0]  cfg_address,
    input  logic [31:0] cfg_data_in,
    input  logic        cfg_op,
    input  logic        cfg_en,
    output logic [31:0] cfg_data_out,
    output logic        cfg_rdy
);

`ifdef FRAME_DEFRAMER_CHECKSUM_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PAYLOAD = 2'd1, ST_CHK = 2'd2} state_t;
    // After the last payload byte the trailer is still owed.
    localparam state_t ST_AFTER = ST_CHK;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PAYLOAD = 2'd1} state_t;
    localparam state_t ST_AFTER = ST_IDLE;
`endif

    state_t          state_q, state_d;
    logic [7:0]      rem_q, rem_d;
    logic [7:0]      len_q, len_d;
    logic            len_full_q, len_full_d;
    logic            enable_q, enable_d;
    logic [31:0]     frames_q, frames_d;
    logic [31:0]     bytes_q, bytes_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [AW:0]     count_q, count_d;
    logic [7:0]      mem_q [DEPTH];
`ifdef FRAME_DEFRAMER_CHECKSUM_EN
    logic [7:0]      xor_q, xor_d;
    logic [31:0]     errors_q, errors_d;
    logic            err_sticky_q, err_sticky_d;
`endif

    logic            din_fire;
    logic            push;
    logic            pop;
    logic            cfg_wr;
    logic            fifo_full;
    logic            fifo_empty;
    logic [31:0]     status_w;
    logic            unused_cfg_bits;

    // Only a few write-data bits are meaningful; fold the rest away.
    assign unused_cfg_bits = ^cfg_data_in[31:1];

    // DEPTH is a power of two, so the count MSB alone marks "full".
    assign fifo_full  = count_q[AW];
    assign fifo_empty = (count_q == '0);

    assign cfg_rdy    = RST_N;
    assign dout_rdy   = ~fifo_empty;
    assign dout_value = fifo_empty ? 8'h00 : mem_q[rptr_q];
    assign len_rdy    = len_full_q;
    assign len_value  = len_q;

    always_comb begin
        din_rdy = 1'b0;
        if (RST_N) begin
            unique case (state_q)
                ST_IDLE:    din_rdy = enable_q & ~len_full_q;
                // The enable bit is not consulted here: a started frame always completes.
                ST_PAYLOAD: din_rdy = ~fifo_full;
`ifdef FRAME_DEFRAMER_CHECKSUM_EN
                ST_CHK:     din_rdy = 1'b1;
`endif
                default:    din_rdy = 1'b0;
            endcase
        end
    end

    assign din_fire = din_en & din_rdy;
    assign push     = din_fire & (state_q == ST_PAYLOAD);
    assign pop      = dout_en & dout_rdy;
    assign cfg_wr   = cfg_en & cfg_op & RST_N;

    // Next-state logic: FSM, length slot, FIFO pointers, counters, cfg writes.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        len_d      = len_q;
        len_full_d = len_full_q;
        enable_d   = enable_q;
        frames_d   = frames_q;
        bytes_d    = bytes_q;
        wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d     = pop  ? rptr_q + 1'b1 : rptr_q;
`ifdef FRAME_DEFRAMER_CHECKSUM_EN
        xor_d        = xor_q;
        errors_d     = errors_q;
        err_sticky_d = err_sticky_q;
`endif

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A header can never coincide with a slot pop: din_rdy is low while full.
        if (len_en && len_full_q) begin
            len_full_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (din_fire) begin
                    len_d      = din_value;
                    len_full_d = 1'b1;
                    rem_d      = din_value;
                    frames_d   = frames_q + 32'd1;
`ifdef FRAME_DEFRAMER_CHECKSUM_EN
                    xor_d      = 8'h00;
`endif
                    state_d    = (din_value == 8'h00) ? ST_AFTER : ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (din_fire) begin
                    rem_d   = rem_q - 8'd1;
                    bytes_d = bytes_q + 32'd1;
`ifdef FRAME_DEFRAMER_CHECKSUM_EN
                    xor_d   = xor_q ^ din_value;
`endif
                    if (rem_q == 8'd1) begin
                        state_d = ST_AFTER;
                    end
                end
            end
`ifdef FRAME_DEFRAMER_CHECKSUM_EN
            ST_CHK: begin
                // Trailer byte is only compared, never buffered.
                if (din_fire) begin
                    if (din_value != xor_q) begin
                        errors_d     = errors_q + 32'd1;
                        err_sticky_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Register writes come last so that a clear beats a same-cycle increment.
        if (cfg_wr) begin
            unique case (cfg_address)
                8'h00: enable_d = cfg_data_in[0];
                8'h01: frames_d = 32'd0;
                8'h02: bytes_d  = 32'd0;
`ifdef FRAME_DEFRAMER_CHECKSUM_EN
                8'h03: if (cfg_data_in[16]) err_sticky_d = 1'b0;
                8'h04: errors_d = 32'd0;
`endif
                default: ;
            endcase
        end
    end

    // Register read path, purely combinational from the address.
    always_comb begin
        status_w        = '0;
        status_w[AW:0]  = count_q;
        status_w[9:8]   = state_q;
        status_w[12]    = len_full_q;
`ifdef FRAME_DEFRAMER_CHECKSUM_EN
        status_w[16]    = err_sticky_q;
`endif
        cfg_data_out = '0;
        if (RST_N && !cfg_op) begin
            unique case (cfg_address)
                8'h00:   cfg_data_out = {31'd0, enable_q};
                8'h01:   cfg_data_out = frames_q;
                8'h02:   cfg_data_out = bytes_q;
                8'h03:   cfg_data_out = status_w;
`ifdef FRAME_DEFRAMER_CHECKSUM_EN
                8'h04:   cfg_data_out = errors_q;
`endif
                default: cfg_data_out = '0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            rem_q      <= 8'd0;
            len_q      <= 8'd0;
            len_full_q <= 1'b0;
            enable_q   <= 1'b1;
            frames_q   <= 32'd0;
            bytes_q    <= 32'd0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
`ifdef FRAME_DEFRAMER_CHECKSUM_EN
            xor_q        <= 8'h00;
            errors_q     <= 32'd0;
            err_sticky_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            len_q      <= len_d;
            len_full_q <= len_full_d;
            enable_q   <= enable_d;
            frames_q   <= frames_d;
            bytes_q    <= bytes_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
`ifdef FRAME_DEFRAMER_CHECKSUM_EN
            xor_q        <= xor_d;
            errors_q     <= errors_d;
            err_sticky_q <= err_sticky_d;
`endif
        end
    end

    // Payload storage: no reset needed, occupancy is tracked by count_q.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wptr_q] <= din_value;
        end
    end

endmodule

// File: doc/frame_deframer.md
Name: frame_deframer

Overview:
- Receive side of the length-prefixed byte framing used by the dut packetizer.
- Accepts a serial byte stream whose first byte is the payload length L, followed by L payload bytes.
- Presents the frame length and the payload bytes on separate method-style interfaces (value/en/rdy).
- Has a small cfg register port for enable, counters and status; sits between the link and the consuming logic.

Parameters:
DEPTH, 16, payload FIFO depth in bytes (power of 2, >= 2)
AW, 4, log2(DEPTH); FIFO pointer width

Ports:
CLK  input  1  clock, all state on rising edge
RST_N  input  1  asynchronous active-low reset
din_value  input  8  incoming stream byte (header or payload)
din_en  input  1  action: byte transferred this cycle; legal only while din_rdy=1
din_rdy  output  1  deframer can accept a byte
dout_en  input  1  actionvalue: consumer pops head payload byte; legal only while dout_rdy=1
dout_value  output  8  head of payload FIFO, valid while dout_rdy=1
dout_rdy  output  1  payload FIFO non-empty
len_en  input  1  actionvalue: consumer takes frame length; legal only while len_rdy=1
len_value  output  8  length of the oldest announced frame
len_rdy  output  1  length slot holds a value
cfg_address  input  8  register address
cfg_data_in  input  32  write data
cfg_op  input  1  1 = write, 0 = read
cfg_en  input  1  cfg access this cycle
cfg_data_out  output  32  read data (combinational from cfg_address), 0 when cfg_op=1
cfg_rdy  output  1  high whenever RST_N=1

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; FIFO empty; len slot empty; counters=0; CTRL.enable=1.
  - din_rdy=0, dout_rdy=0, len_rdy=0, dout_value=0, len_value=0, cfg_data_out=0.
  - Reset mid-frame discards the partial frame and all buffered bytes.
- Handshake:
  - Transfer occurs on a rising edge with en=1 and rdy=1.
  - en while rdy=0 is ignored; no state change.
- FSM states: IDLE (expect header), PAYLOAD (rem bytes outstanding), CHK (only with the optional feature).
- IDLE:
  - din_rdy = enable & ~len_full.
  - On header byte L: latch L into the len slot (len_rdy=1 the next cycle); rem<=L; frames_rx++.
  - L=0 stays in IDLE (empty frame, length still reported). L>0 goes to PAYLOAD.
- PAYLOAD:
  - din_rdy = ~fifo_full; the enable bit is ignored, so the current frame always completes.
  - Each accepted byte is pushed to the FIFO; rem--; bytes_rx++.
  - rem 1->0 goes to IDLE (or CHK).
- Length slot:
  - Single entry; cleared by len_en.
  - Header acceptance while the slot is full is impossible (din_rdy=0).
  - len_en and a new header in the same cycle: not possible, because din_rdy=0 while the slot is full; the header is taken the next cycle.
- Payload FIFO:
  - Circular, wptr/rptr AW bits wrapping modulo DEPTH, occupancy count AW+1 bits.
  - Simultaneous push and pop when full or empty is allowed only if the respective rdy is high: a pop while full frees a slot visible the next cycle; a push while empty is not poppable in the same cycle.
  - Push+pop in one cycle leaves count unchanged.
  - Latency from din acceptance to dout_rdy: 1 cycle.
- cfg registers (32-bit; reads combinational, writes on the accepting edge):
  - 0x00 CTRL: bit0 enable, RW.
  - 0x01 FRAMES: RO, wraps at 2^32; any write clears it.
  - 0x02 BYTES: payload bytes, RO, wraps; any write clears it.
  - 0x03 STATUS: RO. [AW:0] FIFO count; [9:8] state (0 IDLE, 1 PAYLOAD, 2 CHK); bit 12 len_full.
  - 0x04 ERRORS: see optional feature; reads 0 when the feature is absent.
  - Other addresses read 0; writes to them are ignored.
  - A counter clear in the same cycle as an increment: clear wins.

Optional Feature:
- Macro: FRAME_DEFRAMER_CHECKSUM_EN.
- Defined:
  - Each frame carries one trailing byte equal to the XOR of all payload bytes (0x00 for L=0).
  - After the last payload byte (or directly after the header if L=0) the FSM enters CHK.
  - CHK: din_rdy=1; the byte is compared against the running XOR and is not pushed to the FIFO.
  - Mismatch increments ERRORS (0x04, wraps; write clears) and sets sticky STATUS bit 16 (write 1 to bit 16 via 0x03 clears it).
  - Return to IDLE.
- Undefined:
  - No CHK state; no trailer byte.
  - 0x04 and STATUS bit 16 read 0.

Test Plan:
1. Reset, then stream 03 AA BB CC with dout_en/len_en held 1 -> len_value=3 once; dout AA,BB,CC in order; FRAMES=1, BYTES=3.
2. Header 00 then 02 11 22 with len_en=0 -> after first header din_rdy=0 until len_en pops 0; then len=2, dout 11,22.
3. Header 0x14 (20 bytes) with dout_en=0 -> din_rdy drops after 16 payload bytes (STATUS count=16); popping one byte lets exactly one more in; all 20 bytes exit in order, wptr wraps cleanly.
4. Write CTRL=0 mid-frame (frame 04, 2 of 4 bytes sent) -> remaining 2 bytes accepted, then din_rdy=0 in IDLE; write CTRL=1 -> din_rdy=1.
5. Assert RST_N=0 for 1 cycle mid-frame with 3 bytes buffered -> dout_rdy=0, len_rdy=0, counters 0, state IDLE; next header 01 55 produces len 1, dout 55.
6. With FRAME_DEFRAMER_CHECKSUM_EN: frame 02 0F F0 FF -> ERRORS=0; frame 02 0F F0 00 -> ERRORS=1, STATUS[16]=1; payload still delivered.
